// File: rtl/lsu_subword_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_subword_if
// Description : Bundles the core request/response handshake and the 64-bit
//               data-memory port of the sub-word load/store unit.
//               slave  - the load/store unit side
//               master - the core + memory side (drives requests, mem_rd)
// Ports       : req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/
//               req_wdata  (core request)
//               resp_valid/resp_rdata/resp_err (core response)
//               mem_we/mem_a/mem_wd/mem_rd (data memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_subword_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [63:0]       mem_wd;
  logic [63:0]       mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_we, mem_a, mem_wd
  );
endinterface
`default_nettype wire

// File: rtl/lsu_subword.sv
`default_nettype none
// ============================================================================
// Module      : lsu_subword
// Description : Load/store unit between the core memory stage and a 64-bit
//               data memory. Byte/half/word loads are extracted from the
//               addressed dword and sign/zero-extended; sub-dword stores are
//               merged by read-modify-write. Misaligned and out-of-range
//               requests are answered with an error and never touch memory.
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-high
//               bus   - lsu_subword_if.slave (request, response, memory)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_subword #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  lsu_subword_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       mem_wd_q;
  logic              resp_valid_q;
  logic [63:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [5:0]        shamt_d;
  logic [63:0]       lane_d;
  logic [63:0]       ext_d;
  logic [63:0]       mask_d;
  logic [63:0]       merged_d;
  logic              misalign_d;
  logic              oor_d;

  // Load extraction and store merge, both driven from latched request state.
  always_comb begin
    shamt_d = {addr_q[2:0], 3'b000};
    lane_d  = bus.mem_rd >> shamt_d;
    ext_d   = lane_d;
    mask_d  = '1;
    case (size_q)
      2'd0: begin
        ext_d  = {{56{~uns_q & lane_d[7]}}, lane_d[7:0]};
        mask_d = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        ext_d  = {{48{~uns_q & lane_d[15]}}, lane_d[15:0]};
        mask_d = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        ext_d  = {{32{~uns_q & lane_d[31]}}, lane_d[31:0]};
        mask_d = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        ext_d  = lane_d;
        mask_d = '1;
      end
    endcase
    merged_d = (bus.mem_rd & ~(mask_d << shamt_d)) |
               ((wdata_q & mask_d) << shamt_d);
  end

  // Accept-time error checks on the live request; misalignment has priority
  // but both lead to the same error response.
  always_comb begin
    misalign_d = 1'b0;
    case (bus.req_size)
      2'd0:    misalign_d = 1'b0;
      2'd1:    misalign_d = bus.req_addr[0];
      2'd2:    misalign_d = |bus.req_addr[1:0];
      default: misalign_d = |bus.req_addr[2:0];
    endcase
    oor_d = {3'b000, bus.req_addr[ADDR_W-1:3]} >= ADDR_W'(MEM_WORDS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      // Response outputs are single-cycle; they only hold in RESP.
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (misalign_d || oor_d) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= S_RESP;
            end else if (bus.req_we && bus.req_size == 2'd3) begin
              mem_wd_q <= bus.req_wdata;
              state_q  <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (!we_q) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ext_d;
            state_q      <= S_RESP;
          end else begin
            mem_wd_q <= merged_d;
            state_q  <= S_WR;
          end
        end
        S_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  // Gating with reset guarantees no write lands in a reset cycle.
  assign bus.mem_we     = (state_q == S_WR) && !reset;
  assign bus.mem_wd     = mem_wd_q;
  // Dword index presented as index*4.
  assign bus.mem_a      = (state_q != S_IDLE) ? {1'b0, addr_q[ADDR_W-1:3], 2'b00} : '0;

endmodule
`default_nettype wire
